cache_fill_ctrl: RTL and testbench

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_pkg.sv | 14 +
 rtl/fill_counter.sv | 33 +++
 rtl/cache_fill_ctrl.sv | 132 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller: FSM states and block geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fill_state_e;

    localparam int          BLOCK_WORDS    = 8;
    localparam logic [15:0] BLOCK_OFF_MASK = 16'h000F;
    localparam int          WORD_OFF_W     = 3;

endpackage

// File: rtl/fill_counter.sv
// Word-offset counter with synchronous clear and increment.
module fill_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [WORD_OFF_W-1:0] cnt_o
);

    logic [WORD_OFF_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WORD_OFF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block fill controller shared by I- and D-cache: issues one read per word,
// then writes returned words into the selected cache and pulses tag write on the last.
module cache_fill_ctrl #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    output logic        fill_busy,
    output logic        fill_sel,
    output logic        fill_data_we,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        fill_tag_we,
    output logic        fill_done
);
    import cache_pkg::fill_state_e;
    import cache_pkg::ST_IDLE;
    import cache_pkg::ST_ISSUE;
    import cache_pkg::ST_WAIT;
    import cache_pkg::BLOCK_OFF_MASK;
    import cache_pkg::WORD_OFF_W;

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("MEM_LATENCY must be at least 1");
    end
    if (BLOCK_WORDS > (1 << WORD_OFF_W)) begin : g_bad_block
        $error("BLOCK_WORDS exceeds word-offset counter range");
    end

    localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(BLOCK_WORDS - 1);

    fill_state_e           state_q, state_d;
    logic                  sel_q, sel_d;
    logic [15:0]           base_q, base_d;
    logic [WORD_OFF_W-1:0] issue_cnt, recv_cnt;
    logic                  cnt_clr, issue_inc, recv_inc;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (issue_inc),
        .cnt_o (issue_cnt)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (recv_inc),
        .cnt_o (recv_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        base_d       = base_q;
        cnt_clr      = 1'b0;
        issue_inc    = 1'b0;
        recv_inc     = 1'b0;
        mem_en       = 1'b0;
        mem_addr     = '0;
        fill_data_we = 1'b0;
        fill_data    = '0;
        fill_tag_we  = 1'b0;
        fill_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // D-side misses win so loads/stores are not starved by fetch
                if (d_miss || i_miss) begin
                    sel_d   = d_miss;
                    base_d  = (d_miss ? d_miss_addr : i_miss_addr) & ~BLOCK_OFF_MASK;
                    cnt_clr = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en    = 1'b1;
                mem_addr  = base_q + {{(15 - WORD_OFF_W){1'b0}}, issue_cnt, 1'b0};
                issue_inc = 1'b1;
                if (issue_cnt == LAST_WORD) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Returned words are accepted in both ISSUE and WAIT; the last one ends the fill
        if (state_q != ST_IDLE && mem_data_valid) begin
            fill_data_we = 1'b1;
            fill_data    = mem_data;
            recv_inc     = 1'b1;
            if (recv_cnt == LAST_WORD) begin
                fill_tag_we = 1'b1;
                fill_done   = 1'b1;
                state_d     = ST_IDLE;
            end
        end
    end

    assign fill_busy = (state_q != ST_IDLE);
    assign fill_sel  = sel_q;
    assign fill_word = recv_cnt;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: directed table, corner sequences, random traffic.
module tb_cache_fill_ctrl;

    localparam int LAT = 4;
    localparam int BW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, mem_data_valid;
    logic [15:0] i_miss_addr, d_miss_addr, mem_data;
    logic        mem_en, fill_busy, fill_sel, fill_data_we, fill_tag_we, fill_done;
    logic [15:0] mem_addr, fill_data;
    logic [2:0]  fill_word;

    cache_fill_ctrl #(.MEM_LATENCY(LAT), .BLOCK_WORDS(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .fill_busy      (fill_busy),
        .fill_sel       (fill_sel),
        .fill_data_we   (fill_data_we),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .fill_tag_we    (fill_tag_we),
        .fill_done      (fill_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // memory environment
    typedef struct { int due; logic [15:0] addr; } pend_t;
    pend_t memq[$];
    bit mem_auto = 1'b0;
    bit spur_en  = 1'b0;
    int gap_mode = 0;
    int gap_ref  = 0;

    // transaction-level reference model
    bit          m_busy = 1'b0;
    bit          m_sel  = 1'b0;
    logic [15:0] m_base = 16'h0;
    int          m_issued = 0;
    int          m_recv   = 0;
    bit          s_en, s_we, s_done;

    // observation logs
    int          done_log[$];
    bit          done_sel_log[$];
    int          tag_cnt;
    int          d_first, i_first;
    logic [15:0] d_first_addr, i_first_addr;

    typedef struct {
        bit          d;
        logic [15:0] daddr;
        bit          mv;
        logic [15:0] md;
        bit          x_busy;
        bit          x_en;
        logic [15:0] x_addr;
        bit          x_we;
        logic [2:0]  x_word;
        logic [15:0] x_data;
        bit          x_done;
    } vec_t;
    vec_t tbl[16];

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit gate_open();
        case (gap_mode)
            1:       return ((cyc - gap_ref) % 2) == 1;
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clear_logs();
        done_log.delete();
        done_sel_log.delete();
        tag_cnt = 0;
        d_first = -1;
        i_first = -1;
        d_first_addr = 16'h0;
        i_first_addr = 16'h0;
    endtask

    task automatic sample();
        logic [15:0] e_addr, e_data;
        logic [2:0]  e_word;
        logic [40:0] exp_v, act_v;
        if (mem_auto) begin
            mem_data_valid = 1'b0;
            mem_data       = 16'h0;
            if (memq.size() > 0 && memq[0].due <= cyc && gate_open()) begin
                mem_data_valid = 1'b1;
                mem_data       = mem_word(memq[0].addr);
                void'(memq.pop_front());
            end else if (spur_en && memq.size() == 0 && !m_busy && $urandom_range(0, 4) == 0) begin
                mem_data_valid = 1'b1;
                mem_data       = 16'($urandom);
            end
        end
        s_en   = m_busy && (m_issued < BW);
        e_addr = s_en ? (m_base + 16'(2 * m_issued)) : 16'h0;
        s_we   = m_busy && mem_data_valid;
        e_word = s_we ? 3'(m_recv) : 3'd0;
        e_data = s_we ? mem_data : 16'h0;
        s_done = s_we && (m_recv == BW - 1);
        @(negedge clk);
        if (rst) begin
            chk("rst_outputs_zero",
                64'({mem_en, mem_addr, fill_busy, fill_sel, fill_data_we, fill_word,
                     fill_data, fill_tag_we, fill_done}), 64'd0);
        end else begin
            exp_v = {m_busy, s_en, e_addr, s_we, e_word, e_data, s_done, s_done, m_busy & m_sel};
            act_v = {fill_busy, mem_en, mem_en ? mem_addr : 16'h0, fill_data_we,
                     fill_data_we ? fill_word : 3'd0, fill_data_we ? fill_data : 16'h0,
                     fill_tag_we, fill_done, fill_busy & fill_sel};
            chk($sformatf("cycle%0d", cyc), 64'(act_v), 64'(exp_v));
            if (mem_en && mem_auto) memq.push_back('{cyc + LAT, mem_addr});
            if (fill_tag_we) tag_cnt++;
            if (fill_done) begin
                done_log.push_back(cyc);
                done_sel_log.push_back(fill_sel);
            end
            if (mem_en && fill_sel && d_first < 0) begin
                d_first = cyc;
                d_first_addr = mem_addr;
            end
            if (mem_en && !fill_sel && i_first < 0) begin
                i_first = cyc;
                i_first_addr = mem_addr;
            end
        end
    endtask

    task automatic advance();
        bit ev_done, ev_sel;
        ev_done = 1'b0;
        ev_sel  = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_sel  = 1'b0;
            m_issued = 0;
            m_recv   = 0;
        end else if (!m_busy) begin
            if (d_miss || i_miss) begin
                m_busy   = 1'b1;
                m_sel    = d_miss;
                m_base   = (d_miss ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                m_issued = 0;
                m_recv   = 0;
            end
        end else begin
            if (s_en) m_issued++;
            if (s_we) m_recv++;
            if (s_done) begin
                m_busy  = 1'b0;
                ev_done = 1'b1;
                ev_sel  = m_sel;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        // requester drops the served miss after fill_done
        if (ev_done) begin
            if (ev_sel) d_miss = 1'b0;
            else        i_miss = 1'b0;
        end
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (memq.size() > 0 || m_busy); k++) step();
    endtask

    task automatic run_until_dones(int n, int limit);
        for (int k = 0; k < limit && done_log.size() < n; k++) step();
    endtask

    initial begin
        int start;
        bit wait_drain;

        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; mem_data_valid = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; mem_data = 16'h0;
        clear_logs();

        for (int c = 0; c < 16; c++) begin
            tbl[c].d      = (c <= 12);
            tbl[c].daddr  = 16'h1236;
            tbl[c].mv     = (c >= 5 && c <= 12) || (c == 14);
            tbl[c].md     = tbl[c].mv ? 16'(16'hD000 + c) : 16'h0;
            tbl[c].x_busy = (c >= 1 && c <= 12);
            tbl[c].x_en   = (c >= 1 && c <= 8);
            tbl[c].x_addr = tbl[c].x_en ? 16'(16'h1230 + 2 * (c - 1)) : 16'h0;
            tbl[c].x_we   = (c >= 5 && c <= 12);
            tbl[c].x_word = tbl[c].x_we ? 3'(c - 5) : 3'd0;
            tbl[c].x_data = tbl[c].x_we ? tbl[c].md : 16'h0;
            tbl[c].x_done = (c == 12);
        end

        // reset state
        @(posedge clk);
        #1;
        sample();
        chk("reset_busy", 64'(fill_busy), 64'd0);
        advance();
        rst = 1'b0;
        step();
        step();

        // directed D fill with explicit memory timing, then valid in IDLE
        mem_auto = 1'b0;
        clear_logs();
        for (int c = 0; c < 16; c++) begin
            d_miss         = tbl[c].d;
            d_miss_addr    = tbl[c].daddr;
            mem_data_valid = tbl[c].mv;
            mem_data       = tbl[c].md;
            sample();
            chk($sformatf("tbl_row%0d", c),
                64'({fill_busy, mem_en, mem_en ? mem_addr : 16'h0, fill_data_we,
                     fill_data_we ? fill_word : 3'd0, fill_data_we ? fill_data : 16'h0, fill_done}),
                64'({tbl[c].x_busy, tbl[c].x_en, tbl[c].x_addr, tbl[c].x_we,
                     tbl[c].x_word, tbl[c].x_data, tbl[c].x_done}));
            if (c == 12) chk("tbl_done_sel", 64'(fill_sel), 64'd1);
            advance();
        end
        mem_data_valid = 1'b0;
        mem_data = 16'h0;
        mem_auto = 1'b1;

        // simultaneous I and D misses: D first, then I
        clear_logs();
        start = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h2000;
        run_until_dones(2, 60);
        chk("both_done_count", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) begin
            chk("both_d_done_cycle", 64'(done_log[0] - start), 64'd12);
            chk("both_d_done_sel", 64'(done_sel_log[0]), 64'd1);
            chk("both_i_done_sel", 64'(done_sel_log[1]), 64'd0);
        end
        chk("both_d_first_cycle", 64'(d_first - start), 64'd1);
        chk("both_d_first_addr", 64'(d_first_addr), 64'h2000);
        chk("both_i_first_cycle", 64'(i_first - start), 64'd14);
        chk("both_i_first_addr", 64'(i_first_addr), 64'h0040);
        drain();

        // gapped memory returns: valid only every other cycle
        clear_logs();
        start = cyc;
        gap_mode = 1;
        gap_ref = start;
        d_miss = 1'b1; d_miss_addr = 16'h3458;
        run_until_dones(1, 60);
        chk("gap_done_count", 64'(done_log.size()), 64'd1);
        if (done_log.size() == 1) chk("gap_done_cycle", 64'(done_log[0] - start), 64'd19);
        gap_mode = 0;
        drain();

        // asynchronous reset at cycle 6 of a fill
        clear_logs();
        start = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h4000;
        for (int k = 0; k < 6; k++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_zero",
            64'({mem_en, mem_addr, fill_busy, fill_sel, fill_data_we, fill_word,
                 fill_data, fill_tag_we, fill_done}), 64'd0);
        d_miss = 1'b0;
        sample();
        advance();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) step();
        chk("rst_no_tag_write", 64'(tag_cnt), 64'd0);
        chk("rst_no_done", 64'(done_log.size()), 64'd0);
        start = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h4006;
        run_until_dones(1, 40);
        chk("rst_refill_done_count", 64'(done_log.size()), 64'd1);
        if (done_log.size() == 1) chk("rst_refill_done_cycle", 64'(done_log[0] - start), 64'd12);
        drain();

        // miss raised during an ongoing fill waits for fill_done
        clear_logs();
        start = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h0104;
        for (int k = 0; k < 3; k++) step();
        d_miss = 1'b1; d_miss_addr = 16'h0208;
        run_until_dones(2, 60);
        chk("late_done_count", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) begin
            chk("late_i_done_cycle", 64'(done_log[0] - start), 64'd12);
            chk("late_i_done_sel", 64'(done_sel_log[0]), 64'd0);
        end
        chk("late_d_first_cycle", 64'(d_first - start), 64'd14);
        chk("late_d_first_addr", 64'(d_first_addr), 64'h0200);
        drain();

        // randomized traffic with gaps, spurious idle valids and occasional resets
        gap_mode = 2;
        spur_en = 1'b1;
        wait_drain = 1'b0;
        for (int k = 0; k < 2500; k++) begin
            if (wait_drain && memq.size() == 0 && !m_busy) wait_drain = 1'b0;
            if (!wait_drain) begin
                if (!d_miss && $urandom_range(0, 9) == 0) begin
                    d_miss = 1'b1;
                    d_miss_addr = 16'($urandom);
                end
                if (!i_miss && $urandom_range(0, 9) == 0) begin
                    i_miss = 1'b1;
                    i_miss_addr = 16'($urandom);
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                d_miss = 1'b0;
                i_miss = 1'b0;
                step();
                rst = 1'b0;
                wait_drain = 1'b1;
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
